bin2bcd_display: RTL

Sequential binary-to-packed-BCD converter that sits directly upstream of the 8-digit seven-segment driver. It feeds that driver's HEX and display_mode inputs.
Accepts an unsigned binary count over a valid/ready handshake and converts it by iterative double-dabble, one bit per clock. It presents the result as eight BCD nibbles so the display shows decimal.
Out-of-range inputs are flagged and shown as all "E".

---
 rtl/bin2bcd_display.sv | 88 ++++++++
 1 files changed

// File: rtl/bin2bcd_display.sv
// bin2bcd_display: iterative double-dabble binary-to-packed-BCD front end for the 8-digit display
// Optional feature macro: BIN2BCD_OVF_BLANK_EN (overflow blanks the display and keeps HEX)
module bin2bcd_display #(
    parameter int BIN_W   = 27,
    parameter int DIGITS  = 8,
    parameter int MAX_VAL = 99_999_999
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIN_W-1:0]    in_value,
    output logic [4*DIGITS-1:0] HEX,
    output logic                display_mode,
    output logic                done,
    output logic                overflow
);
    localparam int CNT_W = $clog2(BIN_W);
    typedef enum logic {IDLE, CONV} state_t;
    state_t                  state_q;
    logic [BIN_W-1:0]        bin_q;
    logic [4*DIGITS-1:0]     bcd_q;
    logic [4*DIGITS-1:0]     bcd_adj;
    logic [4*DIGITS-1:0]     hex_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    disp_q;
    logic                    done_q;
    logic                    ovf_q;
    logic [4*DIGITS+BIN_W-1:0] shift_d;
    // add-3 correction on every nibble of 5 or more, no carry between nibbles
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign bcd_adj[4*d +: 4] = (bcd_q[4*d +: 4] >= 4'd5) ? bcd_q[4*d +: 4] + 4'd3 : bcd_q[4*d +: 4];
    end
    assign shift_d = {bcd_adj, bin_q} << 1;
    // handshake, one double-dabble iteration per CONV cycle, and registered display outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            hex_q   <= '0;
            disp_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (in_value > BIN_W'(MAX_VAL)) begin
`ifdef BIN2BCD_OVF_BLANK_EN
                            disp_q <= 1'b0;
`else
                            hex_q  <= {DIGITS{4'hE}};
                            disp_q <= 1'b1;
`endif
                            ovf_q  <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            bin_q   <= in_value;
                            bcd_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= CONV;
                        end
                    end
                end
                CONV: begin
                    {bcd_q, bin_q} <= shift_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BIN_W-1)) begin
                        hex_q   <= shift_d[BIN_W +: 4*DIGITS];
                        disp_q  <= 1'b1;
                        ovf_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign in_ready     = (state_q == IDLE);
    assign HEX          = hex_q;
    assign display_mode = disp_q;
    assign done         = done_q;
    assign overflow     = ovf_q;
endmodule
